memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  16  byte-independent word address width
  LINE_WORDS  4  16-bit words per cache line (power of 2)
  MEM_LATENCY  4  cycles from acceptance to response (>=1)
  MEM_DEPTH  4096  words of backing storage (multiple of LINE_WORDS)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  ic_req_valid  in  1  i-cache line-fill request
  ic_req_addr  in  ADDR_W  i-cache line address
  ic_req_ready  out  1  i-cache request accepted this cycle when high with valid
  ic_resp_valid  out  1  one-cycle i-cache fill pulse
  ic_resp_data  out  LINE_WORDS*16  fill line, word 0 in LSBs
  dc_req_valid  in  1  d-cache request
  dc_req_we  in  1  1 = line write-back, 0 = line fill
  dc_req_addr  in  ADDR_W  d-cache line address
  dc_req_wdata  in  LINE_WORDS*16  write-back line
  dc_req_ready  out  1  d-cache request accepted this cycle when high with valid
  dc_resp_valid  out  1  one-cycle d-cache fill/write-ack pulse
  dc_resp_data  out  LINE_WORDS*16  fill line, or echo of written line
  busy  out  1  high in any non-IDLE state

Function
REQ-003 Controller SHALL be the responder for i-cache and d-cache line requests; one transaction in flight at a time.
REQ-004 FSM states SHALL be IDLE, ACCESS, RESPOND; IDLE->ACCESS on acceptance, ACCESS->RESPOND when latency counter reaches 0, RESPOND->IDLE unconditionally.
REQ-005 Ready SHALL be combinational, high only in IDLE, and high for at most one port per cycle.
REQ-006 Single requester in IDLE SHALL be granted; both valid SHALL grant the port not granted last (round-robin via last_grant register).
REQ-007 On acceptance, address, we, wdata and granted port SHALL be latched; latency counter loaded with MEM_LATENCY-1.
REQ-008 Granted port's resp_valid SHALL be high exactly one cycle, MEM_LATENCY cycles after the acceptance cycle; other port's resp_valid stays 0.
REQ-009 Earliest next acceptance SHALL be the cycle after RESPOND (throughput one line per MEM_LATENCY+1 cycles).
REQ-010 Line address SHALL ignore low log2(LINE_WORDS) bits and wrap modulo MEM_DEPTH/LINE_WORDS.
REQ-011 Writes SHALL commit all LINE_WORDS words to storage on the RESPOND cycle; a fill of the same line accepted afterward SHALL return new data.
REQ-012 resp_data SHALL be valid only while resp_valid is high; otherwise holds last value.
REQ-013 Requests deasserted before acceptance SHALL be dropped with no side effects; request signals after acceptance are don't-care.

Reset
REQ-014 While rst high: state=IDLE, counter=0, last_grant=d-cache, all resp_valid=0, ready outputs 0, busy=0, resp_data=0.
REQ-015 Reset mid-transaction SHALL abandon it: no write committed, no response issued.
REQ-016 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-017 Shared package (nand_cpu.svh) SHALL hold mem_state_t enum, mem_port_t {PORT_I, PORT_D}, default LINE_WORDS and MEM_LATENCY constants.
REQ-018 Storage SHALL be a sub-module mem_array (synchronous line-wide write, combinational line read).

Verification
REQ-019 Reset then ic_req addr 0x0010 alone -> ic_req_ready=1 same cycle, ic_resp_valid pulse exactly 4 cycles later, busy high 4 cycles.
REQ-020 dc write 0x0020 data 0x4444_3333_2222_1111, then dc fill 0x0020 -> second response data 0x4444_3333_2222_1111.
REQ-021 Both valid out of reset -> i-cache granted first, d-cache granted cycle after i-cache RESPOND; repeated ties alternate.
REQ-022 Addr 0x0023 vs 0x0020 -> identical data; addr MEM_DEPTH+0x20 -> aliases 0x0020.
REQ-023 rst asserted 2 cycles after dc write accept -> no dc_resp_valid, subsequent fill returns old data, last_grant=d-cache.
REQ-024 MEM_LATENCY=1 -> resp_valid cycle after acceptance; back-to-back requests accepted every 2 cycles.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared types and default sizing for the line-fill memory controller.
package memory_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESPOND
   } mem_state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } mem_port_t;

   localparam int DEF_LINE_WORDS  = 4;
   localparam int DEF_MEM_LATENCY = 4;

endpackage

// File: rtl/mem_array.sv
// Line-wide backing store: synchronous write, combinational read, never cleared.
module mem_array #(
   parameter int LINE_W = 64,
   parameter int LINES  = 1024,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata
);

   logic [LINE_W-1:0] mem [LINES];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   always_comb rdata = mem[addr];

endmodule

// File: rtl/memory_controller.sv
// Single-outstanding line responder arbitrating i-cache and d-cache requests
// round-robin, with a fixed response latency.
module memory_controller
   import memory_controller_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int LINE_WORDS  = DEF_LINE_WORDS,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY,
   parameter int MEM_DEPTH   = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ic_req_valid,
   input  logic [ADDR_W-1:0]        ic_req_addr,
   output logic                     ic_req_ready,
   output logic                     ic_resp_valid,
   output logic [LINE_WORDS*16-1:0] ic_resp_data,
   input  logic                     dc_req_valid,
   input  logic                     dc_req_we,
   input  logic [ADDR_W-1:0]        dc_req_addr,
   input  logic [LINE_WORDS*16-1:0] dc_req_wdata,
   output logic                     dc_req_ready,
   output logic                     dc_resp_valid,
   output logic [LINE_WORDS*16-1:0] dc_resp_data,
   output logic                     busy
);

   localparam int LINE_W = LINE_WORDS * 16;
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int LINES  = MEM_DEPTH / LINE_WORDS;
   localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CNT_W  = $clog2(MEM_LATENCY + 1);

   function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] line_no;
      line_no = a >> OFF_W;
      return IDX_W'(line_no % ADDR_W'(LINES));
   endfunction

   mem_state_t        state, state_next;
   mem_port_t         last_grant, lat_port, grant;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [LINE_W-1:0] lat_wdata;
   logic              accept;
   logic              mem_we;
   logic [LINE_W-1:0] rd_line, resp_line, ic_hold, dc_hold;

   always_comb begin
      grant        = PORT_I;
      accept       = 1'b0;
      ic_req_ready = 1'b0;
      dc_req_ready = 1'b0;
      if (!rst && state == ST_IDLE) begin
         if (ic_req_valid && dc_req_valid)
            grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
         else if (dc_req_valid)
            grant = PORT_D;
         accept       = ic_req_valid || dc_req_valid;
         ic_req_ready = accept && (grant == PORT_I);
         dc_req_ready = accept && (grant == PORT_D);
      end
   end

   // A one-cycle latency has no ACCESS dwell: acceptance goes straight to RESPOND.
   // Otherwise the counter steps down through ACCESS and RESPOND follows the
   // cycle in which it reaches zero.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (accept) state_next = (MEM_LATENCY == 1) ? ST_RESPOND : ST_ACCESS;
         ST_ACCESS:  if (cnt == CNT_W'(1)) state_next = ST_RESPOND;
         ST_RESPOND: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_grant <= PORT_D;
         ic_hold    <= '0;
         dc_hold    <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            last_grant <= grant;
            lat_port   <= grant;
            lat_addr   <= (grant == PORT_D) ? dc_req_addr : ic_req_addr;
            lat_we     <= (grant == PORT_D) && dc_req_we;
            lat_wdata  <= dc_req_wdata;
            cnt        <= CNT_W'(MEM_LATENCY - 1);
         end else if (state == ST_ACCESS) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (state == ST_RESPOND) begin
            if (lat_port == PORT_I) ic_hold <= resp_line;
            else                    dc_hold <= resp_line;
         end
      end
   end

   always_comb begin
      mem_we        = !rst && (state == ST_RESPOND) && lat_we;
      resp_line     = lat_we ? lat_wdata : rd_line;
      busy          = !rst && (state != ST_IDLE);
      ic_resp_valid = !rst && (state == ST_RESPOND) && (lat_port == PORT_I);
      dc_resp_valid = !rst && (state == ST_RESPOND) && (lat_port == PORT_D);
      ic_resp_data  = rst ? '0 : (ic_resp_valid ? resp_line : ic_hold);
      dc_resp_data  = rst ? '0 : (dc_resp_valid ? resp_line : dc_hold);
   end

   mem_array #(
      .LINE_W (LINE_W),
      .LINES  (LINES),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (line_idx(lat_addr)),
      .wdata (lat_wdata),
      .rdata (rd_line)
   );

endmodule

// File: tb/tb_memory_controller.sv
// Directed and randomized checks of memory_controller against a line-array
// reference model, at latency 4 and latency 1.
module tb_memory_controller;

   localparam int LAT = 4;
   localparam logic [63:0] DATA_A = 64'h4444_3333_2222_1111;
   localparam logic [63:0] DATA_B = 64'hdead_beef_cafe_f00d;
   localparam logic [63:0] DATA_C = 64'h0123_4567_89ab_cdef;

   logic clk = 1'b0;
   logic rst;

   logic        ic_req_valid, ic_req_ready, ic_resp_valid;
   logic [15:0] ic_req_addr;
   logic [63:0] ic_resp_data;
   logic        dc_req_valid, dc_req_we, dc_req_ready, dc_resp_valid;
   logic [15:0] dc_req_addr;
   logic [63:0] dc_req_wdata, dc_resp_data;
   logic        busy;

   logic        f_ic_req_valid, f_ic_req_ready, f_ic_resp_valid;
   logic [15:0] f_ic_req_addr;
   logic [63:0] f_ic_resp_data;
   logic        f_dc_req_valid, f_dc_req_we, f_dc_req_ready, f_dc_resp_valid;
   logic [15:0] f_dc_req_addr;
   logic [63:0] f_dc_req_wdata, f_dc_resp_data;
   logic        f_busy;

   always #5 clk = ~clk;

   memory_controller #(.ADDR_W(16), .LINE_WORDS(4), .MEM_LATENCY(LAT), .MEM_DEPTH(4096)) dut (
      .clk(clk), .rst(rst),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
      .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .busy(busy)
   );

   memory_controller #(.ADDR_W(16), .LINE_WORDS(4), .MEM_LATENCY(1), .MEM_DEPTH(4096)) dut_l1 (
      .clk(clk), .rst(rst),
      .ic_req_valid(f_ic_req_valid), .ic_req_addr(f_ic_req_addr), .ic_req_ready(f_ic_req_ready),
      .ic_resp_valid(f_ic_resp_valid), .ic_resp_data(f_ic_resp_data),
      .dc_req_valid(f_dc_req_valid), .dc_req_we(f_dc_req_we), .dc_req_addr(f_dc_req_addr),
      .dc_req_wdata(f_dc_req_wdata), .dc_req_ready(f_dc_req_ready),
      .dc_resp_valid(f_dc_resp_valid), .dc_resp_data(f_dc_resp_data), .busy(f_busy)
   );

   // Reference model: one entry per line, plus whether the line has been written.
   logic [63:0] m_mem [1024];
   bit          m_known [1024];
   bit          m_last_d;
   int          total  = 0;
   int          passed = 0;

   function automatic int unsigned lidx(input logic [15:0] a);
      return (int'(a) / 4) % 1024;
   endfunction

   function automatic logic [15:0] mk_addr(input int unsigned line);
      return 16'(line * 4 + $urandom_range(0, 3) + $urandom_range(0, 15) * 4096);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Called at a falling edge with the controller idle; returns at the falling
   // edge of the first idle cycle after the response.
   task automatic do_txn(input bit iv, input bit dv, input bit we,
                         input logic [15:0] ia, input logic [15:0] da, input logic [63:0] wd);
      bit          g_d;
      bit          have;
      int unsigned li;
      logic [63:0] exp;
      ic_req_valid = iv;  ic_req_addr = ia;
      dc_req_valid = dv;  dc_req_we = we;  dc_req_addr = da;  dc_req_wdata = wd;
      g_d = (iv && dv) ? !m_last_d : dv;
      li  = g_d ? lidx(da) : lidx(ia);
      if (g_d && we) begin
         exp = wd;  have = 1'b1;
      end else begin
         exp = m_mem[li];  have = m_known[li];
      end
      #1;
      chk("ic_ready", ic_req_ready, iv && !g_d);
      chk("dc_ready", dc_req_ready, dv && g_d);
      @(posedge clk);
      m_last_d = g_d;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k < LAT) begin
            ic_req_valid = 1'($urandom_range(0, 1));
            dc_req_valid = 1'($urandom_range(0, 1));
            dc_req_we    = 1'($urandom_range(0, 1));
            ic_req_addr  = 16'($urandom);
            dc_req_addr  = 16'($urandom);
            dc_req_wdata = {$urandom, $urandom};
         end else begin
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
         end
         #1;
         chk("busy_active", busy, 1'b1);
         chk("ic_ready_busy", ic_req_ready, 1'b0);
         chk("dc_ready_busy", dc_req_ready, 1'b0);
         chk("ic_resp_valid", ic_resp_valid, (k == LAT) && !g_d);
         chk("dc_resp_valid", dc_resp_valid, (k == LAT) && g_d);
         if (k == LAT && have) chk("resp_data", g_d ? dc_resp_data : ic_resp_data, exp);
      end
      @(negedge clk);
      chk("busy_idle", busy, 1'b0);
      chk("ic_resp_idle", ic_resp_valid, 1'b0);
      chk("dc_resp_idle", dc_resp_valid, 1'b0);
      if (have) chk("resp_hold", g_d ? dc_resp_data : ic_resp_data, exp);
      if (g_d && we) begin
         m_mem[li]   = wd;
         m_known[li] = 1'b1;
      end
   endtask

   int unsigned pool [8];

   initial begin
      rst = 1'b1;
      ic_req_valid = 1'b0;  ic_req_addr = '0;
      dc_req_valid = 1'b0;  dc_req_we = 1'b0;  dc_req_addr = '0;  dc_req_wdata = '0;
      f_ic_req_valid = 1'b0;  f_ic_req_addr = '0;
      f_dc_req_valid = 1'b0;  f_dc_req_we = 1'b0;  f_dc_req_addr = '0;  f_dc_req_wdata = '0;
      for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
      m_last_d = 1'b1;

      @(negedge clk);
      @(negedge clk);
      ic_req_valid = 1'b1;  dc_req_valid = 1'b1;
      #1;
      chk("rst_ic_ready", ic_req_ready, 1'b0);
      chk("rst_dc_ready", dc_req_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ic_resp_valid", ic_resp_valid, 1'b0);
      chk("rst_dc_resp_valid", dc_resp_valid, 1'b0);
      chk("rst_ic_resp_data", ic_resp_data, 64'h0);
      chk("rst_dc_resp_data", dc_resp_data, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Tie out of reset: i-cache first, then d-cache write commits.
      do_txn(1'b1, 1'b1, 1'b1, 16'h0010, 16'h0020, DATA_A);
      do_txn(1'b1, 1'b1, 1'b1, 16'h0010, 16'h0020, DATA_A);
      do_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 64'h0);
      do_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 64'h0);
      do_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0023, 64'h0);
      do_txn(1'b1, 1'b0, 1'b0, 16'h1020, 16'h0000, 64'h0);

      // Reset two cycles into a write must abandon it.
      dc_req_valid = 1'b1;  dc_req_we = 1'b1;  dc_req_addr = 16'h0020;  dc_req_wdata = DATA_B;
      #1;
      chk("abort_dc_ready", dc_req_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      dc_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;  dc_req_valid = 1'b1;  dc_req_we = 1'b0;
      #1;
      chk("abort_dc_resp_valid", dc_resp_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_dc_ready", dc_req_ready, 1'b0);
      chk("abort_dc_resp_data", dc_resp_data, 64'h0);
      @(negedge clk);
      rst = 1'b0;  dc_req_valid = 1'b0;  m_last_d = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("abort_no_resp", dc_resp_valid, 1'b0);
         chk("abort_idle", busy, 1'b0);
         @(negedge clk);
      end
      do_txn(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0020, 64'h0);
      do_txn(1'b1, 1'b1, 1'b0, 16'h0023, 16'h1020, 64'h0);

      // Randomized traffic over a small pool of lines, each written first.
      for (int i = 0; i < 8; i++) pool[i] = $urandom_range(0, 1023);
      for (int i = 0; i < 8; i++)
         do_txn(1'b0, 1'b1, 1'b1, 16'h0, mk_addr(pool[i]), {$urandom, $urandom});
      for (int n = 0; n < 40; n++) begin
         int unsigned r;
         r = $urandom_range(1, 3);
         do_txn(r[0], r[1], 1'($urandom_range(0, 1)),
                mk_addr(pool[$urandom_range(0, 7)]), mk_addr(pool[$urandom_range(0, 7)]),
                {$urandom, $urandom});
      end

      // Latency-1 instance: response the cycle after acceptance.
      f_dc_req_valid = 1'b1;  f_dc_req_we = 1'b1;  f_dc_req_addr = 16'h0040;  f_dc_req_wdata = DATA_C;
      #1;
      chk("l1_wr_ready", f_dc_req_ready, 1'b1);
      chk("l1_wr_busy0", f_busy, 1'b0);
      @(negedge clk);
      f_dc_req_we = 1'b0;
      #1;
      chk("l1_wr_resp_valid", f_dc_resp_valid, 1'b1);
      chk("l1_wr_resp_data", f_dc_resp_data, DATA_C);
      chk("l1_wr_busy1", f_busy, 1'b1);
      chk("l1_ready_in_respond", f_dc_req_ready, 1'b0);
      @(negedge clk);
      #1;
      chk("l1_rd_ready", f_dc_req_ready, 1'b1);
      chk("l1_rd_resp_gap", f_dc_resp_valid, 1'b0);
      @(negedge clk);
      f_dc_req_valid = 1'b0;
      #1;
      chk("l1_rd_resp_valid", f_dc_resp_valid, 1'b1);
      chk("l1_rd_resp_data", f_dc_resp_data, DATA_C);
      @(negedge clk);
      f_ic_req_valid = 1'b1;  f_ic_req_addr = 16'h0042;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("l1_b2b_ready", f_ic_req_ready, (c % 2) == 0);
         chk("l1_b2b_resp", f_ic_resp_valid, (c % 2) == 1);
         chk("l1_b2b_dc_resp", f_dc_resp_valid, 1'b0);
         if ((c % 2) == 1) chk("l1_b2b_data", f_ic_resp_data, DATA_C);
         @(negedge clk);
      end
      f_ic_req_valid = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
